// File: rtl/cic_comp_pkg.sv
// Shared constants, coefficient table and FSM encoding for the CIC compensation FIR.
// COEF is the first half (centre tap last) of a 15-tap symmetric response summing to 2^15.
package cic_comp_pkg;

  localparam int CW   = 16;
  localparam int NTAP = 15;
  localparam int NH   = (NTAP + 1) / 2;
  localparam int KW   = $clog2(NH);
  localparam int IW   = $clog2(NTAP);

  typedef logic signed [CW-1:0] coef_t;

  // 2*(c0..c6) + c7 = 2*5850 + 21068 = 32768, i.e. unity gain at DC
  localparam coef_t COEF [NH] = '{
    -16'sd40, 16'sd120, -16'sd250, 16'sd420,
    -16'sd700, 16'sd1300, 16'sd5000, 16'sd21068
  };

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_MAC   = 2'd1,
    S_ROUND = 2'd2,
    S_OUT   = 2'd3
  } state_t;

  function automatic int acc_width(input int w);
    return w + CW + 1 + $clog2(NH);
  endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Datapath: sample delay line, symmetric pre-add, coefficient multiply, accumulate,
// and round-half-up / saturate of the accumulator back to W bits.
module cic_comp_mac
  import cic_comp_pkg::*;
#(
  parameter int W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_shift,
  input  logic signed [W-1:0] i_sample,
  input  logic                i_clr,
  input  logic                i_acc,
  input  logic [KW-1:0]       i_k,
  output logic signed [W-1:0] o_sat
);

  localparam int AW = acc_width(W);
  localparam logic signed [AW-1:0] RND = {{(AW-CW+1){1'b0}}, 1'b1, {(CW-2){1'b0}}};

  logic signed [W-1:0]    r_x [NTAP];
  logic signed [AW-1:0]   r_acc;

  logic [IW-1:0]          w_ki;
  logic [IW-1:0]          w_kj;
  logic signed [W-1:0]    w_lo;
  logic signed [W-1:0]    w_hi;
  logic signed [W:0]      w_pre;
  coef_t                  w_coef;
  logic signed [W+CW:0]   w_prod;
  logic signed [AW-1:0]   w_sum;
  logic signed [AW-1:0]   w_sh;
  logic [AW-W:0]          w_top;

  // NOTE: the delay line is only 15 words, so it is reset explicitly instead of left to power-up contents.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NTAP; i++) r_x[i] <= '0;
    end else if (i_shift) begin
      r_x[0] <= i_sample;
      for (int i = 1; i < NTAP; i++) r_x[i] <= r_x[i-1];
    end
  end

  assign w_ki   = {{(IW-KW){1'b0}}, i_k};
  assign w_kj   = IW'(NTAP - 1) - w_ki;
  assign w_lo   = r_x[w_ki];
  assign w_hi   = r_x[w_kj];

  // The centre tap has no mirror partner, so it enters the product unpaired
  assign w_pre  = (i_k == KW'(NH - 1)) ? {w_lo[W-1], w_lo}
                                       : {w_lo[W-1], w_lo} + {w_hi[W-1], w_hi};
  assign w_coef = COEF[i_k];
  assign w_prod = (W+CW+1)'(w_pre) * (W+CW+1)'(w_coef);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
    end else if (i_clr) begin
      r_acc <= '0;
    end else if (i_acc) begin
      r_acc <= r_acc + AW'(w_prod);
    end
  end

  assign w_sum = r_acc + RND;
  assign w_sh  = w_sum >>> (CW - 1);
  assign w_top = w_sh[AW-1:W-1];

  // In range only when every bit above the W-bit sign position repeats it
  assign o_sat = (&w_top || ~|w_top) ? w_sh[W-1:0]
               : (w_top[AW-W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}});

endmodule

// File: rtl/counter.sv
// Generic mod-M counter; advances on i_en and wraps from M-1 back to 0.
module Counter #(
  parameter int M = 2
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 i_en,
  output logic [((M > 1) ? $clog2(M) : 1)-1:0] o_count
);

  localparam int CNT_W = (M > 1) ? $clog2(M) : 1;

  logic [CNT_W-1:0] r_count;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= (r_count == CNT_W'(M - 1)) ? '0 : r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cic_comp_fir.sv
// Decimating symmetric serial-MAC CIC compensation FIR: one output per D accepted samples,
// each output computed over NH MAC cycles followed by a round and an output cycle.
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int W = 10,
  parameter int D = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                eni,
  input  logic signed [W-1:0] in,
  output logic                eno,
  output logic signed [W-1:0] out,
  output logic                busy,
  output logic                ovf
);

  localparam int PW = (D > 1) ? $clog2(D) : 1;

  state_t              r_state;
  logic [KW-1:0]       r_k;
  logic signed [W-1:0] r_out;
  logic                r_eno;
  logic                r_ovf;

  logic [PW-1:0]       w_phase;
  logic                w_accept;
  logic                w_trig;
  logic signed [W-1:0] w_sat;

  assign w_accept = eni && (r_state == S_IDLE);
  assign w_trig   = w_accept && (w_phase == PW'(D - 1));

  Counter #(
    .M (D)
  ) u_phase (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_accept),
    .o_count (w_phase)
  );

  cic_comp_mac #(
    .W (W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .i_shift  (w_accept),
    .i_sample (in),
    .i_clr    (w_trig),
    .i_acc    (r_state == S_MAC),
    .i_k      (r_k),
    .o_sat    (w_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_out   <= '0;
      r_eno   <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_eno <= 1'b0;
      // A sample arriving while a sequence is in flight is lost; remember that until reset
      if (eni && (r_state != S_IDLE)) r_ovf <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (w_trig) begin
            r_state <= S_MAC;
            r_k     <= '0;
          end
        end
        S_MAC: begin
          r_k <= r_k + 1'b1;
          if (r_k == KW'(NH - 1)) r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_out   <= w_sat;
          r_eno   <= 1'b1;
          r_state <= S_OUT;
        end
        S_OUT:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out  = r_out;
  assign eno  = r_eno;
  assign ovf  = r_ovf;
  assign busy = (r_state != S_IDLE);

endmodule

// File: tb/tb_cic_comp_fir.sv
// Self-checking bench: D=1 and D=2 instances, a convolution reference model feeding
// per-instance scoreboards, a table of settled-output vectors and hand-written corner sequences.
module tb_cic_comp_fir;
  import cic_comp_pkg::*;

  localparam int W = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic                eni1, eni2;
  logic signed [W-1:0] in1, in2;
  logic                eno1, eno2, busy1, busy2, ovf1, ovf2;
  logic signed [W-1:0] out1, out2;

  cic_comp_fir #(.W(W), .D(1)) dut1 (
    .clk(clk), .rst(rst), .eni(eni1), .in(in1),
    .eno(eno1), .out(out1), .busy(busy1), .ovf(ovf1)
  );

  cic_comp_fir #(.W(W), .D(2)) dut2 (
    .clk(clk), .rst(rst), .eni(eni2), .in(in2),
    .eno(eno2), .out(out2), .busy(busy2), .ovf(ovf2)
  );

  typedef struct {
    int val;
    int cyc;
  } exp_t;

  typedef struct {
    int pos;
    int neg;
    int exp;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;
  int   n_eno2 = 0;
  exp_t q1[$];
  exp_t q2[$];
  exp_t e1, e2;
  int   h  [NTAP];
  int   m1 [NTAP];
  int   m2 [NTAP];
  int   ph2 = 0;
  vec_t tbl [7];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: direct full-length convolution, round half up at 2^-15, clamp to 10-bit range
  function automatic int model_out(input int x[NTAP]);
    longint acc = 0;
    for (int n = 0; n < NTAP; n++) acc += longint'(h[n]) * longint'(x[n]);
    acc = (acc + 64'sd16384) >>> 15;
    if (acc > 511)  acc = 511;
    if (acc < -512) acc = -512;
    return int'(acc);
  endfunction

  always @(negedge clk) begin
    if (rst && eno1) begin
      if (q1.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut1_unexpected_eno: got eno=1 at cycle %0d, expected no output", cyc);
      end else begin
        e1 = q1.pop_front();
        check("dut1_out", out1, e1.val);
        check("dut1_eno_cycle", cyc, e1.cyc);
      end
    end
    if (rst && eno2) begin
      n_eno2++;
      if (q2.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL dut2_unexpected_eno: got eno=1 at cycle %0d, expected no output", cyc);
      end else begin
        e2 = q2.pop_front();
        check("dut2_out", out2, e2.val);
        check("dut2_eno_cycle", cyc, e2.cyc);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send1(input int v, input bit accept);
    @(negedge clk);
    eni1 = 1'b1;
    in1  = W'(v);
    if (accept) begin
      for (int i = NTAP - 1; i > 0; i--) m1[i] = m1[i-1];
      m1[0] = v;
      q1.push_back('{val: model_out(m1), cyc: cyc + 10});
    end
    @(negedge clk);
    eni1 = 1'b0;
  endtask

  task automatic send2(input int v);
    @(negedge clk);
    eni2 = 1'b1;
    in2  = W'(v);
    for (int i = NTAP - 1; i > 0; i--) m2[i] = m2[i-1];
    m2[0] = v;
    if (ph2 == 1) begin
      q2.push_back('{val: model_out(m2), cyc: cyc + 10});
      ph2 = 0;
    end else begin
      ph2 = 1;
    end
    @(negedge clk);
    eni2 = 1'b0;
  endtask

  initial begin
    for (int n = 0; n < NTAP; n++) begin
      h[n]  = (n < NH) ? int'(COEF[n]) : int'(COEF[NTAP-1-n]);
      m1[n] = 0;
      m2[n] = 0;
    end
    // {sample where h>0, sample where h<0, settled output}
    tbl[0] = '{100, 100, 100};
    tbl[1] = '{-200, -200, -200};
    tbl[2] = '{511, 511, 511};
    tbl[3] = '{511, -512, 511};
    tbl[4] = '{-512, 511, -512};
    tbl[5] = '{-512, -512, -512};
    tbl[6] = '{0, 0, 0};

    rst = 1'b0; eni1 = 1'b0; eni2 = 1'b0; in1 = '0; in2 = '0;
    idle(3);
    check("reset_out", out1, 0);
    check("reset_eno", eno1, 0);
    check("reset_busy", busy1, 0);
    check("reset_ovf", ovf1, 0);
    rst = 1'b1;
    idle(2);

    for (int t = 0; t < 7; t++) begin
      for (int j = 0; j < 20; j++) begin
        send1((h[(j + 10) % NTAP] > 0) ? tbl[t].pos : tbl[t].neg, 1'b1);
        idle(10);
      end
      idle(2);
      check($sformatf("vec%0d_settled", t), out1, tbl[t].exp);
      check($sformatf("vec%0d_idle", t), busy1, 0);
    end

    // Impulse into an all-zero line: successive outputs trace the impulse response
    send1(511, 1'b1);
    idle(10);
    for (int j = 0; j < NTAP; j++) begin
      send1(0, 1'b1);
      idle(10);
    end
    idle(2);
    check("impulse_tail", out1, 0);

    for (int j = 0; j < 20; j++) begin
      send2(-200);
      idle(10);
    end
    idle(2);
    check("dec2_settled", out2, -200);
    check("dec2_eno_count", n_eno2, 10);

    // Overrun: second eni lands 3 cycles after a triggering one
    check("ovf_before", ovf1, 0);
    send1(50, 1'b1);
    idle(1);
    check("busy_in_seq", busy1, 1);
    send1(-300, 1'b0);
    check("ovf_set", ovf1, 1);
    idle(12);
    check("ovf_sticky", ovf1, 1);
    send1(70, 1'b1);
    idle(12);
    check("ovf_still_sticky", ovf1, 1);

    // Reset in the middle of a MAC sequence aborts it
    send1(123, 1'b1);
    idle(3);
    #2;
    rst = 1'b0;
    #1;
    check("midrst_out", out1, 0);
    check("midrst_eno", eno1, 0);
    check("midrst_busy", busy1, 0);
    check("midrst_ovf", ovf1, 0);
    q1.delete();
    q2.delete();
    for (int n = 0; n < NTAP; n++) begin
      m1[n] = 0;
      m2[n] = 0;
    end
    ph2 = 0;
    idle(3);
    rst = 1'b1;
    idle(12);
    check("post_rst_quiet", out1, 0);
    for (int j = 0; j < 6; j++) begin
      send1(300 - 100 * j, 1'b1);
      idle(10);
    end
    idle(4);

    check("q1_drained", q1.size(), 0);
    check("q2_drained", q2.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_comp_fir.md
Name: cic_comp_fir

Overview:
- Decimating, symmetric, serial-MAC FIR placed directly downstream of the CIC decimator.
- Input is the CIC output sample stream with its eno strobe.
- Flattens the CIC sinc^N passband droop and decimates by D.
- Output feeds the baseband back end with a one-cycle output strobe.

Parameters:
- W, 10, input/output sample width, signed two's complement.
- D, 2, decimation factor, ≥1. One output per D accepted inputs.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-low. Low clears all state immediately.
- eni  in  1  input sample strobe, one cycle per sample.
- in  in  W  signed input sample, valid while eni=1.
- eno  out  1  output strobe, one-cycle pulse.
- out  out  W  signed filtered sample, held between strobes.
- busy  out  1  MAC sequence in progress.
- ovf  out  1  sticky overrun flag.

Behaviour:
- Reset values: out=0, eno=0, busy=0, ovf=0, delay line all 0, accumulator 0, phase counter 0, FSM in IDLE.
- Delay line: NTAP-entry shift register x[0..NTAP-1]. An accepted eni shifts in to x[0]; x[0] is the newest sample.
- Accept rule: eni is accepted only in IDLE.
  - eni in any other state: the sample is dropped, ovf is set, and the state does not change. ovf clears only on reset.
- Phase counter: mod-D, advances on every accepted eni.
  - An accepted eni with phase=D-1 moves the FSM IDLE->MAC.
  - Otherwise the FSM stays in IDLE (shift only).
  - D=1: every accepted sample triggers a MAC sequence.
- FSM states: IDLE, MAC, ROUND, OUT.
  - IDLE -> MAC on triggering eni. The accumulator is cleared and tap index k=0.
  - MAC: one tap pair per cycle over k=0..NH-1, where NH=(NTAP+1)/2.
    - Pre-add p = x[k] + x[NTAP-1-k] for k<NH-1. For the centre tap, p = x[NH-1] only.
    - acc += p*COEF[k].
    - After k=NH-1 go to ROUND.
  - ROUND: r = (acc + 2^(CW-2)) >>> (CW-1), arithmetic shift.
  - OUT: out <= sat_W(r), eno=1 for this single cycle, then IDLE.
- busy=1 in MAC, ROUND and OUT.
- Latency: eni high in cycle 0 -> eno high in cycle NH+2 (10 for NTAP=15). Minimum triggering-eni spacing is NH+3 cycles.
- Width rules:
  - Pre-add is W+1 bits.
  - Product is W+1+CW bits.
  - Accumulator is AW = W+CW+1+clog2(NH) bits, so no internal overflow.
- Saturation: clamp to [-2^(W-1), 2^(W-1)-1].
- Coefficients: Q1.(CW-1), symmetric. Sum of the full impulse response = 2^(CW-1), i.e. unity DC gain.
- Reset mid-sequence: the async clear aborts the sequence, and no eno is issued afterwards.

Decomposition:
- Package cic_comp_pkg holds:
  - CW=16, NTAP=15, NH.
  - Coefficient type (signed CW bits) and the COEF[0..NH-1] half-table, which must satisfy the unity-DC rule.
  - FSM state enum.
  - AW derivation function.
- The phase counter is an instance of the existing mod-M Counter module.
- One sub-module: cic_comp_mac (pre-add, multiply, accumulate, round/saturate datapath). The FSM stays in the top level.

Test Plan:
- Reset: hold rst=0 for 3 cycles mid-stream -> out=0, eno=0, busy=0, ovf=0 immediately; the next output reflects only post-reset samples.
- DC, D=1: in=100 on eni every 12 cycles for 20 samples -> after NTAP samples every out=100, eno in cycle 10 after each eni.
- Impulse, D=1: one sample 511, then zeros -> successive outs = sat(round(511*h[n]/2^15)) for n=0..14 (symmetric, h = full coefficient set), then 0.
- Decimation D=2: DC in=-200 -> one eno per 2 accepted eni; settled out=-200.
- Saturation: in=511 constant with a coefficient set whose peak gain exceeds 1 at DC -> out clamps to 511; in=-512 -> out=-512; no wrap.
- Overrun: eni 3 cycles after a triggering eni -> sample dropped, ovf=1 and sticky, the in-flight output is unchanged and delivered on time.
